// File: rtl/parc_core_rob_ctrl_if.sv
// Decode/writeback/commit signal bundle for the reorder-buffer controller.
// The master side (decode/bench) drives requests; the slave side (ROB) answers.
interface parc_core_rob_ctrl_if;
   logic       alloc_val;
   logic       alloc_rdy;
   logic       alloc_wen;
   logic [4:0] alloc_preg;
   logic       alloc_spec;
   logic [3:0] alloc_slot;
   logic       fill_val;
   logic [3:0] fill_slot;
   logic       commit_val;
   logic       commit_wen;
   logic [3:0] commit_slot;
   logic [4:0] commit_preg;
   logic       spec_clr;
   logic       squash_val;
   logic       full;
   logic       empty;

   modport master (
      output alloc_val, alloc_wen, alloc_preg, alloc_spec, fill_val, fill_slot,
             spec_clr, squash_val,
      input  alloc_rdy, alloc_slot, commit_val, commit_wen, commit_slot,
             commit_preg, full, empty
   );

   modport slave (
      input  alloc_val, alloc_wen, alloc_preg, alloc_spec, fill_val, fill_slot,
             spec_clr, squash_val,
      output alloc_rdy, alloc_slot, commit_val, commit_wen, commit_slot,
             commit_preg, full, empty
   );
endinterface

// File: rtl/parc_core_rob_ctrl.sv
// 16-entry in-order reorder buffer: 1-cycle alloc/fill, combinational head commit, alloc stalls on full.
// Squash of speculative entries is built only with PARC_ROB_SQUASH_EN; otherwise squash_val acts as spec_clr.
module parc_core_rob_ctrl (
   input  logic                     clk,
   input  logic                     reset,
   parc_core_rob_ctrl_if.slave      bus
);

   typedef struct packed {
      logic       valid;
      logic       pending;
      logic       wen;
      logic       spec;
      logic [4:0] preg;
   } rob_entry_t;

   rob_entry_t ent [16];
   logic [3:0] head;
   logic [3:0] tail;
   logic [4:0] count;
   logic [4:0] spec_cnt;

   logic       do_squash;
   logic       do_clr;
   logic       alloc_fire;
   logic [4:0] squash_amt;
   logic [4:0] count_nxt;

`ifdef PARC_ROB_SQUASH_EN
   assign do_squash     = bus.squash_val;
   assign do_clr        = bus.spec_clr && !bus.squash_val;
   assign bus.alloc_rdy = !bus.full && !bus.squash_val;
`else
   assign do_squash     = 1'b0;
   assign do_clr        = bus.spec_clr || bus.squash_val;
   assign bus.alloc_rdy = !bus.full;
`endif

   // full looks only at the registered count: a same-cycle commit frees nothing yet
   assign bus.full       = (count == 5'd16);
   assign bus.empty      = (count == 5'd0);
   assign bus.alloc_slot = tail;
   assign alloc_fire     = bus.alloc_val && bus.alloc_rdy;

   assign bus.commit_val  = ent[head].valid && !ent[head].pending && !ent[head].spec;
   assign bus.commit_wen  = bus.commit_val && ent[head].wen;
   assign bus.commit_slot = head;
   assign bus.commit_preg = ent[head].preg;

   assign squash_amt = do_squash ? spec_cnt : 5'd0;
   assign count_nxt  = count + {4'd0, alloc_fire} - {4'd0, bus.commit_val} - squash_amt;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) ent[i] <= '0;
         head     <= 4'd0;
         tail     <= 4'd0;
         count    <= 5'd0;
         spec_cnt <= 5'd0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (do_squash && ent[i].spec) ent[i].valid <= 1'b0;
            if (do_squash || do_clr)      ent[i].spec  <= 1'b0;
         end
         if (bus.fill_val && ent[bus.fill_slot].valid)
            ent[bus.fill_slot].pending <= 1'b0;
         if (bus.commit_val) begin
            ent[head].valid <= 1'b0;
            head            <= head + 4'd1;
         end
         // a spec_clr in the allocation cycle also covers the new entry
         if (alloc_fire)
            ent[tail] <= '{valid:   1'b1,
                           pending: 1'b1,
                           wen:     bus.alloc_wen,
                           spec:    bus.alloc_spec && !do_clr,
                           preg:    bus.alloc_preg};
         if (do_squash)
            tail <= tail - spec_cnt[3:0];
         else if (alloc_fire)
            tail <= tail + 4'd1;
         count <= count_nxt;
         if (do_squash || do_clr)
            spec_cnt <= 5'd0;
         else
            spec_cnt <= spec_cnt + {4'd0, alloc_fire && bus.alloc_spec};
      end
   end

endmodule

// File: tb/tb_parc_core_rob_ctrl.sv
// Directed-vector bench for the reorder-buffer controller; squash checks follow PARC_ROB_SQUASH_EN.
module tb_parc_core_rob_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   parc_core_rob_ctrl_if bus ();

   parc_core_rob_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.alloc_val  = 1'b0;
      bus.alloc_wen  = 1'b0;
      bus.alloc_preg = 5'd0;
      bus.alloc_spec = 1'b0;
      bus.fill_val   = 1'b0;
      bus.fill_slot  = 4'd0;
      bus.spec_clr   = 1'b0;
      bus.squash_val = 1'b0;
   endtask

   // advance one edge, then settle away from it
   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      cyc();
      cyc();
      reset = 1'b0;
      #1;
   endtask

   task automatic alloc(input logic wen, input logic [4:0] preg, input logic spec);
      bus.alloc_val  = 1'b1;
      bus.alloc_wen  = wen;
      bus.alloc_preg = preg;
      bus.alloc_spec = spec;
      cyc();
   endtask

   task automatic fill(input logic [3:0] slot);
      bus.fill_val  = 1'b1;
      bus.fill_slot = slot;
      cyc();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle();
      do_reset();

      chk("rst_alloc_rdy",   32'(bus.alloc_rdy),   32'd1);
      chk("rst_alloc_slot",  32'(bus.alloc_slot),  32'd0);
      chk("rst_commit_val",  32'(bus.commit_val),  32'd0);
      chk("rst_commit_wen",  32'(bus.commit_wen),  32'd0);
      chk("rst_commit_slot", 32'(bus.commit_slot), 32'd0);
      chk("rst_commit_preg", 32'(bus.commit_preg), 32'd0);
      chk("rst_full",        32'(bus.full),        32'd0);
      chk("rst_empty",       32'(bus.empty),       32'd1);

      // out-of-order fills 2,1,0 retire in order
      alloc(1'b1, 5'd10, 1'b0);
      alloc(1'b1, 5'd11, 1'b0);
      alloc(1'b1, 5'd12, 1'b0);
      fill(4'd2);
      chk("ooo_hold_a", 32'(bus.commit_val), 32'd0);
      fill(4'd1);
      chk("ooo_hold_b", 32'(bus.commit_val), 32'd0);
      bus.fill_val  = 1'b1;
      bus.fill_slot = 4'd0;
      #1;
      chk("ooo_no_bypass", 32'(bus.commit_val), 32'd0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk("ooo_cval",  32'(bus.commit_val),  32'd1);
         chk("ooo_cslot", 32'(bus.commit_slot), 32'(i));
         chk("ooo_cpreg", 32'(bus.commit_preg), 32'(10 + i));
         chk("ooo_cwen",  32'(bus.commit_wen),  32'd1);
         cyc();
      end
      chk("ooo_done_cval", 32'(bus.commit_val), 32'd0);
      chk("ooo_empty",     32'(bus.empty),      32'd1);

      // non-writing instruction still retires
      chk("nw_slot", 32'(bus.alloc_slot), 32'd3);
      alloc(1'b0, 5'd7, 1'b0);
      fill(4'd3);
      chk("nw_cval",  32'(bus.commit_val),  32'd1);
      chk("nw_cwen",  32'(bus.commit_wen),  32'd0);
      chk("nw_cslot", 32'(bus.commit_slot), 32'd3);
      chk("nw_cpreg", 32'(bus.commit_preg), 32'd7);
      cyc();
      chk("nw_head_adv", 32'(bus.commit_slot), 32'd4);
      chk("nw_empty",    32'(bus.empty),       32'd1);

      // fill all 16 slots
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.alloc_val  = 1'b1;
         bus.alloc_wen  = 1'b1;
         bus.alloc_preg = 5'(i);
         #1;
         chk("full_slot", 32'(bus.alloc_slot), 32'(i));
         chk("full_rdy",  32'(bus.alloc_rdy),  32'd1);
         cyc();
      end
      chk("full_full", 32'(bus.full),       32'd1);
      chk("full_rdy0", 32'(bus.alloc_rdy),  32'd0);
      chk("full_cval", 32'(bus.commit_val), 32'd0);
      chk("full_ne",   32'(bus.empty),      32'd0);

      // commit from full blocks same-cycle alloc; alloc wraps to slot 0 next cycle
      fill(4'd0);
      bus.alloc_val  = 1'b1;
      bus.alloc_wen  = 1'b1;
      bus.alloc_preg = 5'd30;
      #1;
      chk("wrap_cval",  32'(bus.commit_val),  32'd1);
      chk("wrap_cslot", 32'(bus.commit_slot), 32'd0);
      chk("wrap_rdy0",  32'(bus.alloc_rdy),   32'd0);
      cyc();
      bus.alloc_val  = 1'b1;
      bus.alloc_wen  = 1'b1;
      bus.alloc_preg = 5'd30;
      #1;
      chk("wrap_rdy1",  32'(bus.alloc_rdy),  32'd1);
      chk("wrap_slot0", 32'(bus.alloc_slot), 32'd0);
      chk("wrap_cval0", 32'(bus.commit_val), 32'd0);
      cyc();
      chk("wrap_full", 32'(bus.full),      32'd1);
      chk("wrap_rdy",  32'(bus.alloc_rdy), 32'd0);

      // reset discards live entries
      do_reset();
      for (int i = 0; i < 7; i++) alloc(1'b1, 5'(i + 1), 1'b0);
      fill(4'd0);
      chk("rr_pre_cval", 32'(bus.commit_val), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("rr_empty", 32'(bus.empty),      32'd1);
      chk("rr_cval",  32'(bus.commit_val), 32'd0);
      chk("rr_slot",  32'(bus.alloc_slot), 32'd0);
      chk("rr_full",  32'(bus.full),       32'd0);

      // spec_clr releases held entries, including one allocated in the same cycle
      do_reset();
      alloc(1'b1, 5'd5, 1'b1);
      fill(4'd0);
      chk("sc_hold", 32'(bus.commit_val), 32'd0);
      bus.spec_clr = 1'b1;
      alloc(1'b1, 5'd6, 1'b1);
      chk("sc_c0_val",  32'(bus.commit_val),  32'd1);
      chk("sc_c0_preg", 32'(bus.commit_preg), 32'd5);
      fill(4'd1);
      chk("sc_c1_val",  32'(bus.commit_val),  32'd1);
      chk("sc_c1_slot", 32'(bus.commit_slot), 32'd1);
      cyc();
      chk("sc_empty", 32'(bus.empty), 32'd1);

`ifdef PARC_ROB_SQUASH_EN
      // tail=5, slots 3,4 speculative, head slot 0 commits in the squash cycle
      do_reset();
      for (int i = 0; i < 5; i++) alloc(1'b1, 5'(i + 1), (i >= 3));
      fill(4'd0);
      bus.squash_val = 1'b1;
      #1;
      chk("sq_tail_pre", 32'(bus.alloc_slot),  32'd5);
      chk("sq_rdy0",     32'(bus.alloc_rdy),   32'd0);
      chk("sq_cval",     32'(bus.commit_val),  32'd1);
      chk("sq_cslot",    32'(bus.commit_slot), 32'd0);
      cyc();
      chk("sq_tail", 32'(bus.alloc_slot), 32'd3);
      fill(4'd4);
      bus.alloc_val  = 1'b1;
      bus.alloc_wen  = 1'b1;
      bus.alloc_preg = 5'd9;
      #1;
      chk("sq_realloc", 32'(bus.alloc_slot), 32'd3);
      cyc();
      fill(4'd1);
      fill(4'd2);
      fill(4'd3);
      cyc();
      chk("sq_empty",    32'(bus.empty),      32'd1);
      chk("sq_cval_end", 32'(bus.commit_val), 32'd0);
      chk("sq_tail_end", 32'(bus.alloc_slot), 32'd4);
`else
      // without squash support, squash_val behaves as spec_clr
      chk("ns_slot", 32'(bus.alloc_slot), 32'd2);
      alloc(1'b1, 5'd8, 1'b1);
      fill(4'd2);
      chk("ns_hold", 32'(bus.commit_val), 32'd0);
      bus.squash_val = 1'b1;
      #1;
      chk("ns_rdy", 32'(bus.alloc_rdy), 32'd1);
      cyc();
      chk("ns_cval",  32'(bus.commit_val),  32'd1);
      chk("ns_cslot", 32'(bus.commit_slot), 32'd2);
      chk("ns_cpreg", 32'(bus.commit_preg), 32'd8);
      cyc();
      chk("ns_empty", 32'(bus.empty), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
